// File: rtl/req_enc_pkg.sv
// req_enc_pkg
//   Shared definitions for the registered 8-to-3 request encoder:
//   request/code widths, the presenter FSM state type and a one-hot helper
//   used to build the retire mask from a presented code.
package req_enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot vector with bit 'i' set.
    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// prio_enc8
//   Combinational 8-input priority encoder.
//   Ports:
//     vec  in  [7:0]  candidate vector
//     idx  out [2:0]  index of the winning bit (0 when vec == 0)
//     any  out        vec has at least one bit set
//   HIGH_FIRST=1 gives bit 7 the highest priority, 0 gives bit 0.
module prio_enc8
    import req_enc_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic [N_REQ-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Scan toward the highest-priority end; the last hit wins.
    always_comb begin
        idx = '0;
        any = |vec;
        if (HIGH_FIRST) begin
            for (int i = 0; i < N_REQ; i++)
                if (vec[i]) idx = CODE_W'(i);
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--)
                if (vec[i]) idx = CODE_W'(i);
        end
    end

endmodule

// File: rtl/req_encoder_8to3.sv
// req_encoder_8to3
//   Registered 8-to-3 priority encoder with a valid/ack handshake.
//   Request lines are captured (level or rising edge) into a pending
//   register; the highest-priority pending line is presented as a 3-bit
//   code and retired from pending when the consumer acks it.
//   Ports:
//     clk      in        clock, rising edge
//     rst      in        asynchronous active-high reset
//     req      in  [7:0] request lines
//     flush    in        synchronous clear of pending/valid/overrun
//     ack      in        consumer takes the current code (only while valid)
//     code     out [2:0] presented index
//     valid    out       code is meaningful
//     pending  out [7:0] registered pending vector
//     overrun  out       sticky: edge landed on an already-pending bit
module req_encoder_8to3
    import req_enc_pkg::*;
#(
    parameter bit EDGE_MODE  = 1'b0,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              flush,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [N_REQ-1:0]  pending,
    output logic              overrun
);

    state_t             state;
    logic [N_REQ-1:0]   req_d;
    logic [N_REQ-1:0]   cap;
    logic [N_REQ-1:0]   ret;
    logic [N_REQ-1:0]   avail;
    logic [CODE_W-1:0]  nxt_idx;
    logic               nxt_any;

    assign cap   = EDGE_MODE ? (req & ~req_d) : req;
    assign ret   = (valid && ack) ? onehot(code) : '0;
    // Encode only what was already registered, minus the line being retired;
    // bits captured this edge become visible one cycle later.
    assign avail = pending & ~ret;

    prio_enc8 #(
        .HIGH_FIRST (HIGH_FIRST)
    ) u_prio (
        .vec (avail),
        .idx (nxt_idx),
        .any (nxt_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req_d   <= '0;
            pending <= '0;
            code    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            req_d <= req;
            if (flush) begin
                // code intentionally keeps its last value
                state   <= IDLE;
                pending <= '0;
                valid   <= 1'b0;
                overrun <= 1'b0;
            end else begin
                // Set dominates clear: a retired bit captured again stays pending.
                pending <= avail | cap;
                if (EDGE_MODE && |(cap & avail))
                    overrun <= 1'b1;
                unique case (state)
                    IDLE: begin
                        if (nxt_any) begin
                            code  <= nxt_idx;
                            valid <= 1'b1;
                            state <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        // Held stable until acked; no preemption.
                        if (ack) begin
                            if (nxt_any) begin
                                code <= nxt_idx;
                            end else begin
                                valid <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
